// File: rtl/phase_seq_pkg.sv
// Shared state encoding and default sizing for the instruction-phase sequencer.
package phase_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC1 = 3'd2,
    EXEC2 = 3'd3,
    HOLD  = 3'd4,
    HALT  = 3'd5,
    FAULT = 3'd6
  } seq_state_t;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/seq_watchdog.sv
// Counts consecutive stalled EXEC1 cycles; expired flags a stall that has
// already lasted TIMEOUT cycles and is still being requested.
module seq_watchdog
  import phase_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] wait_cnt;

  // Saturates at TIMEOUT; any non-stall cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!active) begin
      wait_cnt <= '0;
    end else if (wait_cnt != W'(TIMEOUT)) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  assign expired = active && (wait_cnt == W'(TIMEOUT));

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase FSM producing one-hot fetch/exec1/exec2 strobes plus
// run/halt/step control and debug counters. Stall watchdog: SEQ_TIMEOUT_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             extra,
  input  logic             loop,
  input  logic             halt,
  input  logic             step_mode,
  input  logic             step,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             running,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  seq_state_t state, state_nxt;
  logic       retire;
  logic       stall;
  logic       expired;

`ifdef SEQ_TIMEOUT_EN
  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  ((state == EXEC1) && loop),
    .expired (expired)
  );
`else
  // Without the watchdog, stalls are unbounded and TIMEOUT has no effect.
  localparam int unused_timeout = TIMEOUT;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    stall     = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = EXEC1;
      EXEC1: begin
        // halt outranks loop; loop outranks extra because the decoder holds
        // Extra high for the whole of a multi-cycle wait.
        if (halt) begin
          state_nxt = HALT;
          retire    = 1'b1;
        end else if (loop) begin
          stall = 1'b1;
          if (expired) state_nxt = FAULT;
        end else if (extra) begin
          state_nxt = EXEC2;
        end else begin
          retire    = 1'b1;
          state_nxt = step_mode ? HOLD : FETCH;
        end
      end
      EXEC2: begin
        retire    = 1'b1;
        state_nxt = step_mode ? HOLD : FETCH;
      end
      HOLD:  if (step || !step_mode) state_nxt = FETCH;
      HALT:  if (start) state_nxt = FETCH;
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fetch   = (state == FETCH);
    exec1   = (state == EXEC1);
    exec2   = (state == EXEC2);
    running = (state == FETCH) || (state == EXEC1) || (state == EXEC2);
    halted  = (state == HALT);
`ifdef SEQ_TIMEOUT_EN
    fault   = (state == FAULT);
`else
    fault   = 1'b0;
`endif
  end

  // Debug counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (stall)  stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized scoreboard bench: an instruction-level model predicts the phase
// seen after every clock edge; a monitor pops and compares each cycle.
module tb_phase_sequencer;

  localparam int CNT_W = 6;
`ifdef SEQ_TIMEOUT_EN
  localparam int TB_TO = 4;
  localparam int MAXL  = 4;
`else
  localparam int TB_TO = 64;
  localparam int MAXL  = 9;
`endif

  localparam byte P_IDLE  = "I";
  localparam byte P_FETCH = "F";
  localparam byte P_E1    = "1";
  localparam byte P_E2    = "2";
  localparam byte P_HOLD  = "H";
  localparam byte P_HALT  = "S";
  localparam byte P_FAULT = "X";

  logic             clk = 1'b0;
  logic             rst_n, start, extra, loop, halt, step_mode, step;
  logic             fetch, exec1, exec2, running, halted, fault;
  logic [CNT_W-1:0] instr_count, stall_count;

  typedef struct {
    byte              ph;
    logic [CNT_W-1:0] ic;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t             q[$];
  logic [CNT_W-1:0] m_instr, m_stall;
  int               vectors = 0;
  int               miscompares = 0;

  phase_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TB_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .extra       (extra),
    .loop        (loop),
    .halt        (halt),
    .step_mode   (step_mode),
    .step        (step),
    .fetch       (fetch),
    .exec1       (exec1),
    .exec2       (exec2),
    .running     (running),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count),
    .stall_count (stall_count)
  );

  initial forever #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and record the phase expected after the edge.
  task automatic tick(input bit s, ex, lp, ht, sm, st, input byte ph);
    exp_t e;
    @(negedge clk);
    start = s; extra = ex; loop = lp; halt = ht; step_mode = sm; step = st;
    e.ph = ph; e.ic = m_instr; e.sc = m_stall;
    q.push_back(e);
  endtask

  task automatic noise_tick(input byte ph);
    tick(rb(), rb(), rb(), rb(), rb(), rb(), ph);
  endtask

  // One instruction starting in FETCH; always returns with FETCH expected.
  task automatic run_instr(input int n_loop, input bit ext, hlt, hl_loop, sm);
    noise_tick(P_E1);
    for (int i = 0; i < n_loop; i++) begin
      m_stall++;
      tick(rb(), rb(), 1'b1, 1'b0, rb(), rb(), P_E1);
    end
    if (hlt) begin
      m_instr++;
      tick(rb(), rb(), hl_loop, 1'b1, rb(), rb(), P_HALT);
      repeat (int'($urandom_range(0, 3))) tick(1'b0, rb(), rb(), rb(), rb(), rb(), P_HALT);
      tick(1'b1, rb(), rb(), rb(), rb(), rb(), P_FETCH);
    end else begin
      if (ext) begin
        tick(rb(), 1'b1, 1'b0, 1'b0, rb(), rb(), P_E2);
        m_instr++;
        tick(rb(), rb(), rb(), rb(), sm, rb(), sm ? P_HOLD : P_FETCH);
      end else begin
        m_instr++;
        tick(rb(), 1'b0, 1'b0, 1'b0, sm, rb(), sm ? P_HOLD : P_FETCH);
      end
      if (sm) begin
        repeat (int'($urandom_range(0, 3))) tick(rb(), rb(), rb(), rb(), 1'b1, 1'b0, P_HOLD);
        if (rb()) tick(rb(), rb(), rb(), rb(), rb(), 1'b1, P_FETCH);
        else      tick(rb(), rb(), rb(), rb(), 1'b0, 1'b0, P_FETCH);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_fetch"},   32'(fetch),   0);
    chk({tag, "_exec1"},   32'(exec1),   0);
    chk({tag, "_exec2"},   32'(exec2),   0);
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_halted"},  32'(halted),  0);
    chk({tag, "_fault"},   32'(fault),   0);
    chk({tag, "_instr"},   32'(instr_count), 0);
    chk({tag, "_stall"},   32'(stall_count), 0);
  endtask

  // Reset lands between edges to show it acts without a clock.
  task automatic async_reset_and_restart();
    @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1 check_cleared("async_rst");
    m_instr = '0;
    m_stall = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, rb(), rb(), rb(), rb(), rb(), P_IDLE);
    tick(1'b1, rb(), rb(), rb(), rb(), rb(), P_FETCH);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("fetch",   32'(fetch),   32'(e.ph == P_FETCH));
        chk("exec1",   32'(exec1),   32'(e.ph == P_E1));
        chk("exec2",   32'(exec2),   32'(e.ph == P_E2));
        chk("running", 32'(running), 32'(e.ph == P_FETCH || e.ph == P_E1 || e.ph == P_E2));
        chk("halted",  32'(halted),  32'(e.ph == P_HALT));
        chk("fault",   32'(fault),   32'(e.ph == P_FAULT));
        chk("instr_count", 32'(instr_count), 32'(e.ic));
        chk("stall_count", 32'(stall_count), 32'(e.sc));
      end
    end
  end

  initial begin : stimulus
    int n, r;
    rst_n = 1'b0;
    start = 1'b0; extra = 1'b0; loop = 1'b0; halt = 1'b0; step_mode = 1'b0; step = 1'b0;
    m_instr = '0;
    m_stall = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    tick(1'b0, rb(), rb(), rb(), rb(), rb(), P_IDLE);
    tick(1'b0, rb(), rb(), rb(), rb(), rb(), P_IDLE);
    tick(1'b1, rb(), rb(), rb(), rb(), rb(), P_FETCH);

    repeat (5) run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr((MAXL < 7) ? MAXL : 7, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(2, 1'b1, 1'b1, 1'b1, 1'b0);
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_instr(1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of an instruction.
    noise_tick(P_E1);
    async_reset_and_restart();

`ifdef SEQ_TIMEOUT_EN
    noise_tick(P_E1);
    for (int i = 0; i < TB_TO; i++) begin
      m_stall++;
      tick(rb(), rb(), 1'b1, 1'b0, rb(), rb(), P_E1);
    end
    m_stall++;
    tick(rb(), rb(), 1'b1, 1'b0, rb(), rb(), P_FAULT);
    repeat (3) noise_tick(P_FAULT);
    async_reset_and_restart();
    run_instr(TB_TO, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(TB_TO, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    repeat (150) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXL)) : 0;
      r = int'($urandom_range(0, 7));
      run_instr(n, rb(), r == 0, rb(), $urandom_range(0, 3) == 0);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
